fft_result_reader: RTL and testbench

Read-out sequencer on the output side of `fft_top`. On the rising edge of the FFT ready flag, it walks all four result RAM banks in bank-major order: bank 0 addresses 0..511, then bank 1, bank 2, bank 3. It drives the banks' read-address ports and re-times the returned real-part words through a small credit-controlled FIFO. The result is a valid/ready sample stream with index and last markers for the downstream consumer (host interface, magnitude unit).

---
 rtl/fft_result_reader.sv | 154 +++++++++++++++
 tb/tb_fft_result_reader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_result_reader.sv
// Bank-major read-out sequencer for the four FFT result RAMs. It re-times the returned words
// through a credit-controlled FIFO and presents them as a valid/ready stream.
module fft_result_reader #(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 9,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic            iCLK,
  input  logic            iRESET,
  input  logic            iRDY,
  input  logic [DW-1:0]   iDATA_RE_0,
  input  logic [DW-1:0]   iDATA_RE_1,
  input  logic [DW-1:0]   iDATA_RE_2,
  input  logic [DW-1:0]   iDATA_RE_3,
  output logic [AW-1:0]   oADDR_RD_0,
  output logic [AW-1:0]   oADDR_RD_1,
  output logic [AW-1:0]   oADDR_RD_2,
  output logic [AW-1:0]   oADDR_RD_3,
  output logic [DW-1:0]   oDATA,
  output logic [AW+1:0]   oINDEX,
  output logic            oVALID,
  input  logic            iREADY,
  output logic            oLAST,
  output logic            oBUSY,
  output logic            oDONE
);

  localparam int unsigned IW = AW + 2;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + RD_LAT + 1) + 1;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic                rdy_q;
  logic [IW-1:0]       rd_idx_q;
  logic [AW-1:0]       addr_hold_q;
  logic [RD_LAT-1:0]   dl_vld_q;
  logic [IW-1:0]       dl_idx_q [RD_LAT];
  logic [DW-1:0]       fifo_data_q [FIFO_DEPTH];
  logic [IW-1:0]       fifo_idx_q [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       occ_q, occ_d;

  logic                rdy_rise;
  logic                fifo_empty;
  logic                push, pop, issue;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       credit_used;
  logic [DW-1:0]       ret_data;
  logic [IW-1:0]       ret_idx;
  logic [AW-1:0]       addr_rd;

  assign rdy_rise   = iRDY & ~rdy_q;
  assign fifo_empty = (occ_q == '0);
  assign pop        = ~fifo_empty & iREADY;
  assign push       = dl_vld_q[RD_LAT-1];
  assign ret_idx    = dl_idx_q[RD_LAT-1];

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LAT; i++) begin
      inflight = inflight + CW'(dl_vld_q[i]);
    end
  end

  // A same-cycle pop already frees its slot, which keeps the stream gap-free at iREADY=1.
  assign credit_used = inflight + occ_q - CW'(pop);
  assign issue       = (state_q == StRead) && (credit_used < CW'(FIFO_DEPTH));
  assign occ_d       = occ_q + CW'(push) - CW'(pop);

  always_comb begin
    case (ret_idx[IW-1:AW])
      2'd0:    ret_data = iDATA_RE_0;
      2'd1:    ret_data = iDATA_RE_1;
      2'd2:    ret_data = iDATA_RE_2;
      default: ret_data = iDATA_RE_3;
    endcase
  end

  // State register and control counters.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q     <= StIdle;
      rdy_q       <= 1'b0;
      rd_idx_q    <= '0;
      addr_hold_q <= '0;
      dl_vld_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= iRDY;
      if (issue) begin
        rd_idx_q    <= rd_idx_q + 1'b1;
        addr_hold_q <= rd_idx_q[AW-1:0];
      end
      dl_vld_q[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        dl_vld_q[i] <= dl_vld_q[i-1];
      end
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      occ_q <= occ_d;
    end
  end

  // Payload storage needs no reset; the valid bits and pointers above qualify it.
  always_ff @(posedge iCLK) begin
    dl_idx_q[0] <= rd_idx_q;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      dl_idx_q[i] <= dl_idx_q[i-1];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ret_data;
      fifo_idx_q[wr_ptr_q]  <= ret_idx;
    end
  end

  // Next-state logic. DRAIN looks one cycle ahead so DONE follows the last beat directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (rdy_rise) state_d = StRead;
      StRead:  if (issue && (&rd_idx_q)) state_d = StDrain;
      StDrain: if (credit_used == '0) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs.
  always_comb begin
    addr_rd = issue ? rd_idx_q[AW-1:0] : addr_hold_q;
    oVALID  = ~fifo_empty;
    oDATA   = fifo_empty ? '0 : fifo_data_q[rd_ptr_q];
    oINDEX  = fifo_empty ? '0 : fifo_idx_q[rd_ptr_q];
    oLAST   = ~fifo_empty & (&fifo_idx_q[rd_ptr_q]);
    oBUSY   = (state_q != StIdle);
    oDONE   = (state_q == StDone);
  end

  assign oADDR_RD_0 = addr_rd;
  assign oADDR_RD_1 = addr_rd;
  assign oADDR_RD_2 = addr_rd;
  assign oADDR_RD_3 = addr_rd;

endmodule

// File: tb/tb_fft_result_reader.sv
// Scoreboard bench for fft_result_reader: banked RAM model, random back-pressure and
// an index-ordered reference of every readout.
module tb_fft_result_reader;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int RD_LAT = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int N = 2048;

  logic          iCLK = 1'b0;
  logic          iRESET, iRDY, iREADY;
  logic [DW-1:0] iDATA_RE_0, iDATA_RE_1, iDATA_RE_2, iDATA_RE_3;
  logic [AW-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
  logic [DW-1:0] oDATA;
  logic [AW+1:0] oINDEX;
  logic          oVALID, oLAST, oBUSY, oDONE;

  fft_result_reader #(.DW(DW), .AW(AW), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iRDY(iRDY),
    .iDATA_RE_0(iDATA_RE_0), .iDATA_RE_1(iDATA_RE_1),
    .iDATA_RE_2(iDATA_RE_2), .iDATA_RE_3(iDATA_RE_3),
    .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
    .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
    .oDATA(oDATA), .oINDEX(oINDEX), .oVALID(oVALID), .iREADY(iREADY),
    .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  // RAM banks: address seen in cycle t, data visible in cycle t+RD_LAT.
  logic [DW-1:0] mem [4][512];
  logic [DW-1:0] pipe [4][RD_LAT];
  logic [AW-1:0] addr [4];
  assign addr[0] = oADDR_RD_0;
  assign addr[1] = oADDR_RD_1;
  assign addr[2] = oADDR_RD_2;
  assign addr[3] = oADDR_RD_3;
  always @(posedge iCLK) begin
    for (int b = 0; b < 4; b++) begin
      pipe[b][0] <= mem[b][addr[b]];
      for (int s = 1; s < RD_LAT; s++) pipe[b][s] <= pipe[b][s-1];
    end
  end
  assign iDATA_RE_0 = pipe[0][RD_LAT-1];
  assign iDATA_RE_1 = pipe[1][RD_LAT-1];
  assign iDATA_RE_2 = pipe[2][RD_LAT-1];
  assign iDATA_RE_3 = pipe[3][RD_LAT-1];

  typedef struct {
    logic [AW+1:0] idx;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 1;  // 0: ready low, 1: ready high, 2: random
  int beats = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -1;
  int e_cyc = 0;
  logic [DW-1:0] d0, dlast;

  always @(posedge iCLK) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial begin
    iREADY = 1'b1;
    forever begin
      @(posedge iCLK);
      #1;
      case (rmode)
        0:       iREADY = 1'b0;
        1:       iREADY = 1'b1;
        default: iREADY = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: pops the scoreboard on every transfer and checks hold-stability during stalls.
  initial begin
    bit stall = 0;
    logic [DW-1:0] hd;
    logic [AW+1:0] hi;
    logic hl;
    exp_t e;
    forever begin
      @(negedge iCLK);
      if (iRESET) begin
        stall = 0;
      end else begin
        if (stall)
          chk(oVALID && oDATA == hd && oINDEX == hi && oLAST == hl, "stall_hold",
              longint'({oVALID, oINDEX, oDATA}), longint'({1'b1, hi, hd}));
        if (oLAST && !oVALID) chk(0, "last_without_valid", 1, 0);
        if (oVALID && iREADY) begin
          if (sb.size() == 0) begin
            chk(0, "unexpected_beat", longint'(oINDEX), -1);
          end else begin
            e = sb.pop_front();
            chk(oINDEX == e.idx && oDATA == e.data, "beat_idx_data",
                longint'({oINDEX, oDATA}), longint'({e.idx, e.data}));
            chk(oLAST == (e.idx == 11'(N - 1)), "beat_last", longint'(oLAST),
                longint'(e.idx == 11'(N - 1)));
            if (e.idx == 0) d0 = oDATA;
            if (e.idx == 11'(N - 1)) dlast = oDATA;
          end
          beats++;
          if (oLAST) last_cyc = cyc;
        end
        stall = oVALID && !iREADY;
        hd = oDATA;
        hi = oINDEX;
        hl = oLAST;
        if (oDONE) begin
          done_cnt++;
          done_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic preload();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 512; a++) mem[b][a] = 16'(b * 512 + a);
  endtask

  // Reference: one readout yields every point once, in bank-major index order.
  task automatic start_readout(input bit hold_rdy);
    @(posedge iCLK);
    #1;
    for (int i = 0; i < N; i++) begin
      exp_t x;
      x.idx = 11'(i);
      x.data = mem[i / 512][i % 512];
      sb.push_back(x);
    end
    iRDY = 1'b1;
    e_cyc = cyc;
    @(posedge iCLK);
    #1;
    if (!hold_rdy) iRDY = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    @(negedge iCLK);
    while (!oDONE && t < 20000) begin
      @(negedge iCLK);
      t++;
    end
    chk(oDONE, name, longint'(oDONE), 1);
  endtask

  task automatic wait_beats(input int n);
    int base = beats;
    int t = 0;
    while (beats - base < n && t < 20000) begin
      @(negedge iCLK);
      t++;
    end
    chk(beats - base >= n, "beat_wait", beats - base, n);
  endtask

  task automatic chk_zero(input string name);
    logic [66:0] v;
    v = {oVALID, oLAST, oBUSY, oDONE, oDATA, oINDEX, oADDR_RD_0, oADDR_RD_1, oADDR_RD_2,
         oADDR_RD_3};
    chk(v == '0, name, longint'(|v), 0);
  endtask

  initial begin
    int fv, nv, dbase;
    iRESET = 1'b1;
    iRDY = 1'b0;
    preload();
    repeat (3) @(posedge iCLK);
    #1;
    chk_zero("reset_outputs");
    iRESET = 1'b0;
    @(negedge iCLK);
    chk_zero("idle_outputs");

    // Full readout at full throughput: latency, gap-free, single DONE.
    rmode = 1;
    dbase = done_cnt;
    start_readout(0);
    fv = -1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge iCLK);
      if (c == 1)
        chk(oADDR_RD_0 == 0 && oADDR_RD_3 == 0 && oBUSY, "first_addr",
            longint'(oADDR_RD_0), 0);
      if (oVALID && fv < 0) fv = c;
    end
    chk(fv == 4, "first_valid_latency", fv, 4);
    wait_done("done_a");
    chk(last_cyc == e_cyc + 4 + N - 1, "last_cycle", last_cyc - e_cyc, 4 + N - 1);
    chk(done_cyc == last_cyc + 1, "done_after_last", done_cyc - last_cyc, 1);
    @(negedge iCLK);
    chk(!oBUSY, "busy_falls", longint'(oBUSY), 0);
    repeat (5) @(negedge iCLK);
    chk(done_cnt - dbase == 1, "done_pulse_count", done_cnt - dbase, 1);
    chk(sb.size() == 0, "sb_empty_a", sb.size(), 0);

    // Random back-pressure.
    rmode = 2;
    start_readout(0);
    wait_done("done_b");
    repeat (3) @(negedge iCLK);
    chk(sb.size() == 0, "sb_empty_b", sb.size(), 0);

    // Long stall: four reads then address frozen, head stays at index 0.
    rmode = 0;
    @(posedge iCLK);
    start_readout(0);
    for (int c = 1; c <= 100; c++) begin
      @(negedge iCLK);
      if (c <= 4)
        chk(oADDR_RD_0 == 9'(c - 1) && oADDR_RD_2 == 9'(c - 1), "stall_addr_seq",
            longint'(oADDR_RD_0), c - 1);
      if (c == 100) begin
        chk(oADDR_RD_0 == 3 && oADDR_RD_1 == 3 && oADDR_RD_2 == 3 && oADDR_RD_3 == 3,
            "addr_frozen", longint'(oADDR_RD_0), 3);
        chk(oVALID && oDATA == 0 && oINDEX == 0, "stall_head", longint'({oVALID, oDATA}),
            longint'({1'b1, 16'h0}));
      end
    end
    rmode = 1;
    wait_done("done_c");
    repeat (3) @(negedge iCLK);
    chk(sb.size() == 0, "sb_empty_c", sb.size(), 0);

    // Edge during readout is ignored; held-high iRDY does not retrigger.
    start_readout(0);
    wait_beats(500);
    @(posedge iCLK);
    #1;
    iRDY = 1'b1;
    wait_done("done_d");
    chk(last_cyc == e_cyc + 4 + N - 1, "uninterrupted", last_cyc - e_cyc, 4 + N - 1);
    nv = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge iCLK);
      if (c > 0 && (oVALID || oBUSY)) nv++;
    end
    chk(nv == 0, "no_retrigger", nv, 0);
    chk(sb.size() == 0, "sb_empty_d", sb.size(), 0);
    iRDY = 1'b0;
    start_readout(0);
    wait_done("done_d2");
    repeat (3) @(negedge iCLK);
    chk(sb.size() == 0, "sb_empty_d2", sb.size(), 0);

    // Reset mid-readout aborts; next readout restarts from index 0.
    start_readout(0);
    wait_beats(700);
    @(posedge iCLK);
    #1;
    iRESET = 1'b1;
    @(posedge iCLK);
    #1;
    iRESET = 1'b0;
    sb.delete();
    chk_zero("abort_outputs");
    nv = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge iCLK);
      if (oVALID) nv++;
    end
    chk(nv == 0, "no_valid_after_abort", nv, 0);
    rmode = 2;
    start_readout(0);
    wait_done("done_e");
    repeat (3) @(negedge iCLK);
    chk(sb.size() == 0, "sb_empty_e", sb.size(), 0);

    // Signed extremes pass through untouched.
    mem[0][0] = 16'h7FFF;
    mem[3][511] = 16'h8000;
    start_readout(0);
    wait_done("done_f");
    repeat (3) @(negedge iCLK);
    chk($signed(d0) == 32767, "max_pos_idx0", longint'($signed(d0)), 32767);
    chk($signed(dlast) == -32768, "max_neg_idx2047", longint'($signed(dlast)), -32768);
    chk(sb.size() == 0, "sb_empty_f", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
